// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory handshake and IF/ID pipeline register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, pend_pc, pend_n, skid, skid_n, tgt, pc4;
  logic ld_fetch, ld_skid, bubble;
  assign tgt       = redirect_pc & ~32'h3;
  assign pc4       = pc + 32'd4;
  assign imem_req  = rst_n && state != HOLD;
  assign imem_addr = pc;
  assign id_opcode = id_instr[31:26];
  // next-state, PC selection and IF/ID load/flush decisions; redirect wins over ack and stall
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    pend_n   = pend_pc;
    skid_n   = skid;
    ld_fetch = 1'b0;
    ld_skid  = 1'b0;
    bubble   = 1'b0;
    case (state)
      FETCH: begin
        if (redirect) begin
          bubble  = 1'b1;
          pc_n    = imem_ack ? tgt : pc;
          pend_n  = imem_ack ? pend_pc : tgt;
          state_n = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          pc_n     = pc4;
          ld_fetch = !stall;
          skid_n   = stall ? imem_rdata : skid;
          state_n  = stall ? HOLD : FETCH;
        end else begin
          bubble = !stall;
        end
      end
      HOLD: begin
        bubble  = redirect;
        pc_n    = redirect ? tgt : pc;
        ld_skid = !redirect && !stall;
        state_n = (redirect || !stall) ? FETCH : HOLD;
      end
      DRAIN: begin
        bubble  = redirect;
        pend_n  = redirect ? tgt : pend_pc;
        pc_n    = imem_ack ? (redirect ? tgt : pend_pc) : pc;
        state_n = imem_ack ? FETCH : DRAIN;
      end
      default: state_n = FETCH;
    endcase
  end
  // state, PC and IF/ID registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC & ~32'h3;
      pend_pc  <= '0;
      skid     <= '0;
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_pc4   <= '0;
      id_instr <= NOP_INSTR;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_n;
      skid    <= skid_n;
      if (bubble) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end else if (ld_fetch) begin
        id_valid <= 1'b1;
        id_pc    <= pc;
        id_pc4   <= pc4;
        id_instr <= imem_rdata;
      end else if (ld_skid) begin
        id_valid <= 1'b1;
        id_pc    <= pc - 32'd4;
        id_pc4   <= pc;
        id_instr <= skid;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage stream, wait states, stall, redirect and reset
module tb_fetch_stage;
  logic        clk = 0, rst_n = 0, imem_ack = 1, stall = 0, redirect = 0;
  logic [31:0] redirect_pc = 0, imem_rdata;
  logic        imem_req, id_valid, u1_req, u1_valid;
  logic [31:0] imem_addr, id_pc, id_pc4, id_instr, u1_addr, u1_pc, u1_pc4, u1_instr;
  logic [5:0]  id_opcode, u1_op;
  int pass = 0, total = 0;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return {a[7:2], 2'b11, a[23:0]};
  endfunction

  assign imem_rdata = ins(imem_addr);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_instr(id_instr), .id_opcode(id_opcode)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst_n(rst_n), .imem_req(u1_req), .imem_addr(u1_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_valid(u1_valid), .id_pc(u1_pc), .id_pc4(u1_pc4),
    .id_instr(u1_instr), .id_opcode(u1_op)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; imem_ack = 1; stall = 0; redirect = 0;
    step(); step();
    total++;
    if ({imem_req, imem_addr, id_valid, id_pc, id_pc4, id_instr, id_opcode} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 6'h0})
      $display("FAIL reset: got req=%b addr=%h v=%b pc=%h pc4=%h instr=%h op=%h exp all zero", imem_req, imem_addr, id_valid, id_pc, id_pc4, id_instr, id_opcode);
    else pass++;
    rst_n = 1;
    #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0})
      $display("FAIL req_after_reset: got req=%b addr=%h exp 1/00000000", imem_req, imem_addr);
    else pass++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({id_valid, id_pc, id_pc4, id_instr, id_opcode, imem_addr} !== {1'b1, 32'(4*i), 32'(4*i+4), ins(32'(4*i)), 6'(i), 32'(4*i+4)})
        $display("FAIL stream%0d: got v=%b pc=%h pc4=%h instr=%h op=%h addr=%h exp pc=%h", i, id_valid, id_pc, id_pc4, id_instr, id_opcode, imem_addr, 4*i);
      else pass++;
    end
  endtask

  task automatic test_wait();
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({imem_req, imem_addr, id_valid, id_instr} !== {1'b1, 32'h8, 1'b0, 32'h0})
        $display("FAIL wait%0d: got req=%b addr=%h v=%b instr=%h exp 1/8/0/0", i, imem_req, imem_addr, id_valid, id_instr);
      else pass++;
    end
    imem_ack = 1;
    step();
    total++;
    if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 32'h8, ins(32'h8), 32'hC})
      $display("FAIL wait_deliver: got v=%b pc=%h instr=%h addr=%h exp 1/8/%h/c", id_valid, id_pc, id_instr, imem_addr, ins(32'h8));
    else pass++;
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({imem_req, id_valid, id_pc, id_instr} !== {1'b0, 1'b1, 32'h8, ins(32'h8)})
        $display("FAIL stall_hold%0d: got req=%b v=%b pc=%h instr=%h exp 0/1/8", i, imem_req, id_valid, id_pc, id_instr);
      else pass++;
    end
    stall = 0;
    step();
    total++;
    if ({id_valid, id_pc, id_pc4, id_instr, imem_req, imem_addr} !== {1'b1, 32'hC, 32'h10, ins(32'hC), 1'b1, 32'h10})
      $display("FAIL stall_release: got v=%b pc=%h pc4=%h instr=%h req=%b addr=%h exp pc=c addr=10", id_valid, id_pc, id_pc4, id_instr, imem_req, imem_addr);
    else pass++;
    step();
    total++;
    if ({id_valid, id_pc, imem_addr} !== {1'b1, 32'h10, 32'h14})
      $display("FAIL stall_resume: got v=%b pc=%h addr=%h exp 1/10/14", id_valid, id_pc, imem_addr);
    else pass++;
  endtask

  task automatic test_drain();
    imem_ack = 0; redirect = 1; redirect_pc = 32'h103;
    step();
    redirect = 0;
    total++;
    if ({imem_req, imem_addr, id_valid, id_instr} !== {1'b1, 32'h14, 1'b0, 32'h0})
      $display("FAIL drain_enter: got req=%b addr=%h v=%b instr=%h exp 1/14/0/0", imem_req, imem_addr, id_valid, id_instr);
    else pass++;
    step();
    total++;
    if ({imem_addr, id_valid} !== {32'h14, 1'b0})
      $display("FAIL drain_wait: got addr=%h v=%b exp 14/0", imem_addr, id_valid);
    else pass++;
    imem_ack = 1;
    step();
    total++;
    if ({imem_req, imem_addr, id_valid, id_instr} !== {1'b1, 32'h100, 1'b0, 32'h0})
      $display("FAIL drain_ack: got req=%b addr=%h v=%b instr=%h exp 1/100/0/0", imem_req, imem_addr, id_valid, id_instr);
    else pass++;
    step();
    total++;
    if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 32'h100, ins(32'h100), 32'h104})
      $display("FAIL drain_target: got v=%b pc=%h instr=%h addr=%h exp 1/100/%h/104", id_valid, id_pc, id_instr, imem_addr, ins(32'h100));
    else pass++;
  endtask

  task automatic test_redirect_hold();
    stall = 1;
    step();
    total++;
    if ({imem_req, id_pc} !== {1'b0, 32'h100})
      $display("FAIL hold_enter: got req=%b pc=%h exp 0/100", imem_req, id_pc);
    else pass++;
    redirect = 1; redirect_pc = 32'h200;
    step();
    redirect = 0; stall = 0;
    total++;
    if ({id_valid, id_instr, imem_req, imem_addr} !== {1'b0, 32'h0, 1'b1, 32'h200})
      $display("FAIL hold_redirect: got v=%b instr=%h req=%b addr=%h exp 0/0/1/200", id_valid, id_instr, imem_req, imem_addr);
    else pass++;
    step();
    total++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h200, ins(32'h200)})
      $display("FAIL hold_target: got v=%b pc=%h instr=%h exp 1/200", id_valid, id_pc, id_instr);
    else pass++;
  endtask

  task automatic test_redirect_fetch();
    redirect = 1; redirect_pc = 32'h40;
    step();
    redirect = 0;
    total++;
    if ({id_valid, imem_addr} !== {1'b0, 32'h40})
      $display("FAIL fetch_redirect_bubble: got v=%b addr=%h exp 0/40", id_valid, imem_addr);
    else pass++;
    step();
    total++;
    if ({id_valid, id_pc, id_opcode} !== {1'b1, 32'h40, 6'h10})
      $display("FAIL fetch_redirect_target: got v=%b pc=%h op=%h exp 1/40/10", id_valid, id_pc, id_opcode);
    else pass++;
  endtask

  task automatic test_wrap_and_reset();
    rst_n = 0;
    step();
    total++;
    if ({u1_req, u1_addr, imem_req} !== {1'b0, 32'hFFFF_FFFC, 1'b0})
      $display("FAIL wrap_reset: got u1_req=%b u1_addr=%h req=%b exp 0/fffffffc/0", u1_req, u1_addr, imem_req);
    else pass++;
    rst_n = 1;
    step();
    total++;
    if ({u1_req, u1_addr, u1_valid, u1_pc, u1_pc4, u1_instr, u1_op} !== {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0, ins(32'h0), 6'h0})
      $display("FAIL wrap: got req=%b addr=%h v=%b pc=%h pc4=%h instr=%h op=%h exp addr=0 pc=fffffffc pc4=0", u1_req, u1_addr, u1_valid, u1_pc, u1_pc4, u1_instr, u1_op);
    else pass++;
    imem_ack = 0; redirect = 1; redirect_pc = 32'h300;
    step();
    redirect = 0;
    step();
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h4})
      $display("FAIL drain_before_reset: got req=%b addr=%h exp 1/4", imem_req, imem_addr);
    else pass++;
    rst_n = 0;
    step();
    total++;
    if ({imem_req, imem_addr, id_valid} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL reset_mid_drain: got req=%b addr=%h v=%b exp 0/0/0", imem_req, imem_addr, id_valid);
    else pass++;
    rst_n = 1; imem_ack = 1;
    step();
    total++;
    if ({id_valid, id_pc, imem_addr} !== {1'b1, 32'h0, 32'h4})
      $display("FAIL after_drain_reset: got v=%b pc=%h addr=%h exp 1/0/4", id_valid, id_pc, imem_addr);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_drain();
    test_redirect_hold();
    test_redirect_fetch();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
